// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter
//   Time-shares one ALU (operands plus ALUop/funct decode) between two
//   requesters: req0 = main execute stage, req1 = branch/address unit.
//   Contention is resolved round-robin. Each operation runs through
//   IDLE (grant) -> EXEC (ALU inputs held for ALU_LAT cycles) -> RESP
//   (result held until the owner takes it).
// Parameters
//   DATA_W   operand/result width
//   ALU_LAT  cycles from driving ALU inputs to sampling alu_result (1..15)
// Ports
//   clk_i, rst_i          clock (rising edge), async active-high reset
//   req_valid_i/ready_o   per-requester request handshake (2 bits)
//   req_aluop_i/funct_i   per-requester decode fields, {req1,req0} packed
//   req_a_i/req_b_i       per-requester operands, {req1,req0} packed
//   alu_*_o               registered ALU inputs, held while an op is in flight
//   alu_result_i/zero_i   ALU result and zero flag
//   rsp_valid_o/ready_i   per-requester response handshake (2 bits)
//   rsp_data_o/zero_o     latched result and zero flag, shared
module alu_share_arbiter #(
   parameter int DATA_W  = 32,
   parameter int ALU_LAT = 1
) (
   input  logic                   clk_i,
   input  logic                   rst_i,
   input  logic [1:0]             req_valid_i,
   output logic [1:0]             req_ready_o,
   input  logic [1:0][2:0]        req_aluop_i,
   input  logic [1:0][5:0]        req_funct_i,
   input  logic [1:0][DATA_W-1:0] req_a_i,
   input  logic [1:0][DATA_W-1:0] req_b_i,
   output logic [2:0]             alu_aluop_o,
   output logic [5:0]             alu_funct_o,
   output logic [DATA_W-1:0]      alu_a_o,
   output logic [DATA_W-1:0]      alu_b_o,
   input  logic [DATA_W-1:0]      alu_result_i,
   input  logic                   alu_zero_i,
   output logic [1:0]             rsp_valid_o,
   input  logic [1:0]             rsp_ready_i,
   output logic [DATA_W-1:0]      rsp_data_o,
   output logic                   rsp_zero_o
);

   typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

   typedef struct packed {
      logic [2:0]        aluop;
      logic [5:0]        funct;
      logic [DATA_W-1:0] a;
      logic [DATA_W-1:0] b;
   } alu_op_t;

   state_t            state_q, state_d;
   alu_op_t           op_q, op_d;
   logic              grant_q, grant_d;
   logic              last_q, last_d;
   logic [3:0]        cnt_q, cnt_d;
   logic [1:0]        rsp_vld_q, rsp_vld_d;
   logic [DATA_W-1:0] data_q, data_d;
   logic              zero_q, zero_d;

   logic any_req;
   logic win;

   assign any_req = |req_valid_i;
   // Both pending: take the one not served last. Otherwise the lone
   // requester wins, which is req1 exactly when bit 1 is set.
   assign win = (&req_valid_i) ? ~last_q : req_valid_i[1];

   // State register
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q   <= IDLE;
         op_q      <= '0;
         grant_q   <= 1'b0;
         last_q    <= 1'b1;
         cnt_q     <= '0;
         rsp_vld_q <= '0;
         data_q    <= '0;
         zero_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         op_q      <= op_d;
         grant_q   <= grant_d;
         last_q    <= last_d;
         cnt_q     <= cnt_d;
         rsp_vld_q <= rsp_vld_d;
         data_q    <= data_d;
         zero_q    <= zero_d;
      end
   end

   // Next state
   always_comb begin
      state_d   = state_q;
      op_d      = op_q;
      grant_d   = grant_q;
      last_d    = last_q;
      cnt_d     = cnt_q;
      rsp_vld_d = rsp_vld_q;
      data_d    = data_q;
      zero_d    = zero_q;
      case (state_q)
         IDLE: begin
            if (any_req) begin
               grant_d    = win;
               op_d.aluop = req_aluop_i[win];
               op_d.funct = req_funct_i[win];
               op_d.a     = req_a_i[win];
               op_d.b     = req_b_i[win];
               cnt_d      = 4'(ALU_LAT);
               state_d    = EXEC;
            end
         end
         EXEC: begin
            cnt_d = cnt_q - 4'd1;
            if (cnt_q == 4'd1) begin
               data_d    = alu_result_i;
               zero_d    = alu_zero_i;
               rsp_vld_d = grant_q ? 2'b10 : 2'b01;
               state_d   = RESP;
            end
         end
         RESP: begin
            // Only the owner's rsp_ready matters.
            if (rsp_ready_i[grant_q]) begin
               rsp_vld_d = '0;
               last_d    = grant_q;
               state_d   = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Outputs
   always_comb begin
      req_ready_o = '0;
      if (state_q == IDLE && any_req) req_ready_o[win] = 1'b1;
   end

   assign alu_aluop_o = op_q.aluop;
   assign alu_funct_o = op_q.funct;
   assign alu_a_o     = op_q.a;
   assign alu_b_o     = op_q.b;
   assign rsp_valid_o = rsp_vld_q;
   assign rsp_data_o  = data_q;
   assign rsp_zero_o  = zero_q;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed bench for alu_share_arbiter: one instance with ALU_LAT=1 and a
// combinational ALU model, one with ALU_LAT=3 fed by a 2-stage delayed ALU
// model so that early sampling returns a stale result.
module tb_alu_share_arbiter;
   localparam int DW = 32;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   int chk  = 0;
   int pass = 0;

   // ALU_LAT=1 instance
   logic [1:0]         req_valid, req_ready, rsp_valid, rsp_ready;
   logic [1:0][2:0]    req_aluop;
   logic [1:0][5:0]    req_funct;
   logic [1:0][DW-1:0] req_a, req_b;
   logic [2:0]         alu_aluop;
   logic [5:0]         alu_funct;
   logic [DW-1:0]      alu_a, alu_b, alu_result, rsp_data;
   logic               alu_zero, rsp_zero;

   // ALU_LAT=3 instance
   logic [1:0]         l3_req_valid, l3_req_ready, l3_rsp_valid, l3_rsp_ready;
   logic [1:0][2:0]    l3_req_aluop;
   logic [1:0][5:0]    l3_req_funct;
   logic [1:0][DW-1:0] l3_req_a, l3_req_b;
   logic [2:0]         l3_alu_aluop;
   logic [5:0]         l3_alu_funct;
   logic [DW-1:0]      l3_alu_a, l3_alu_b, l3_alu_result, l3_rsp_data;
   logic               l3_alu_zero, l3_rsp_zero;
   logic [DW-1:0]      l3_d1, l3_d2;

   function automatic logic [DW-1:0] alu_f(input logic [2:0] op, input logic [5:0] fn,
                                           input logic [DW-1:0] a, input logic [DW-1:0] b);
      if (op == 3'b111 && fn == 6'b000001) return a + b;
      if (op == 3'b101) return a - b;
      return a | b;
   endfunction

   assign alu_result = alu_f(alu_aluop, alu_funct, alu_a, alu_b);
   assign alu_zero   = (alu_result == '0);

   always_ff @(posedge clk) begin
      l3_d1 <= alu_f(l3_alu_aluop, l3_alu_funct, l3_alu_a, l3_alu_b);
      l3_d2 <= l3_d1;
   end
   assign l3_alu_result = l3_d2;
   assign l3_alu_zero   = (l3_d2 == '0);

   alu_share_arbiter #(.DATA_W(DW), .ALU_LAT(1)) u_dut (
      .clk_i(clk), .rst_i(rst),
      .req_valid_i(req_valid), .req_ready_o(req_ready),
      .req_aluop_i(req_aluop), .req_funct_i(req_funct),
      .req_a_i(req_a), .req_b_i(req_b),
      .alu_aluop_o(alu_aluop), .alu_funct_o(alu_funct),
      .alu_a_o(alu_a), .alu_b_o(alu_b),
      .alu_result_i(alu_result), .alu_zero_i(alu_zero),
      .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready),
      .rsp_data_o(rsp_data), .rsp_zero_o(rsp_zero)
   );

   alu_share_arbiter #(.DATA_W(DW), .ALU_LAT(3)) u_lat3 (
      .clk_i(clk), .rst_i(rst),
      .req_valid_i(l3_req_valid), .req_ready_o(l3_req_ready),
      .req_aluop_i(l3_req_aluop), .req_funct_i(l3_req_funct),
      .req_a_i(l3_req_a), .req_b_i(l3_req_b),
      .alu_aluop_o(l3_alu_aluop), .alu_funct_o(l3_alu_funct),
      .alu_a_o(l3_alu_a), .alu_b_o(l3_alu_b),
      .alu_result_i(l3_alu_result), .alu_zero_i(l3_alu_zero),
      .rsp_valid_o(l3_rsp_valid), .rsp_ready_i(l3_rsp_ready),
      .rsp_data_o(l3_rsp_data), .rsp_zero_o(l3_rsp_zero)
   );

   task automatic set_op(input int r, input logic [2:0] op, input logic [5:0] fn,
                         input logic [DW-1:0] a, input logic [DW-1:0] b);
      req_aluop[r] = op;
      req_funct[r] = fn;
      req_a[r]     = a;
      req_b[r]     = b;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      req_valid = '0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
   endtask

   // Issue one op on requester r; return at the negedge where rsp_valid is high.
   task automatic issue_wait(input int r, input logic [2:0] op, input logic [5:0] fn,
                             input logic [DW-1:0] a, input logic [DW-1:0] b);
      set_op(r, op, fn, a, b);
      req_valid = (r == 1) ? 2'b10 : 2'b01;
      #1;
      for (int c = 0; c < 10 && req_ready == 2'b00; c++) @(negedge clk);
      @(posedge clk); #1;
      req_valid = '0;
      @(negedge clk);
      for (int c = 0; c < 10 && rsp_valid == 2'b00; c++) @(negedge clk);
   endtask

   task automatic test_reset();
      rst = 1'b1;
      req_valid = '0; rsp_ready = '0; req_aluop = '0; req_funct = '0; req_a = '0; req_b = '0;
      l3_req_valid = '0; l3_rsp_ready = '0; l3_req_aluop = '0; l3_req_funct = '0;
      l3_req_a = '0; l3_req_b = '0;
      repeat (2) @(negedge clk);
      chk++; if (req_ready !== 2'b00) $display("FAIL rst_req_ready got=%b exp=00", req_ready); else pass++;
      chk++; if (rsp_valid !== 2'b00) $display("FAIL rst_rsp_valid got=%b exp=00", rsp_valid); else pass++;
      chk++; if ({alu_aluop, alu_funct, alu_a, alu_b} !== '0)
         $display("FAIL rst_alu got=%h/%h/%h/%h exp=0", alu_aluop, alu_funct, alu_a, alu_b); else pass++;
      chk++; if ({rsp_data, rsp_zero} !== '0)
         $display("FAIL rst_rsp_data got=%h/%b exp=0/0", rsp_data, rsp_zero); else pass++;
      rst = 1'b0;
      set_op(0, 3'b111, 6'b000001, 32'd3, 32'd4);
      req_valid = 2'b01;
      @(posedge clk); #1;
      req_valid = '0;
      @(negedge clk);
      chk++; if (alu_a !== 32'd3) $display("FAIL rst_pre_exec_a got=%0d exp=3", alu_a); else pass++;
      rst = 1'b1; #1;
      chk++; if (rsp_valid !== 2'b00) $display("FAIL rst_mid_rsp_valid got=%b exp=00", rsp_valid); else pass++;
      chk++; if (req_ready !== 2'b00) $display("FAIL rst_mid_req_ready got=%b exp=00", req_ready); else pass++;
      chk++; if ({alu_a, alu_b} !== '0) $display("FAIL rst_mid_alu got=%h/%h exp=0", alu_a, alu_b); else pass++;
      @(negedge clk);
      chk++; if (rsp_valid !== 2'b00) $display("FAIL rst_abort_rsp got=%b exp=00", rsp_valid); else pass++;
      set_op(1, 3'b111, 6'b000001, 32'd8, 32'd9);
      req_valid = 2'b11;
      rst = 1'b0; #1;
      chk++; if (req_ready !== 2'b01) $display("FAIL rst_first_grant got=%b exp=01", req_ready); else pass++;
      rsp_ready = 2'b11;
      @(posedge clk); #1;
      req_valid = '0;
      @(negedge clk);
      chk++; if (alu_a !== 32'd3) $display("FAIL rst_first_op_a got=%0d exp=3", alu_a); else pass++;
      repeat (4) @(negedge clk);
   endtask

   task automatic test_single();
      rsp_ready = 2'b01;
      set_op(0, 3'b111, 6'b000001, 32'd5, 32'd7);
      req_valid = 2'b01; #1;
      chk++; if (req_ready !== 2'b01) $display("FAIL single_ready got=%b exp=01", req_ready); else pass++;
      @(posedge clk); #1;
      req_valid = '0;
      @(negedge clk);
      chk++; if (req_ready !== 2'b00) $display("FAIL single_ready_drop got=%b exp=00", req_ready); else pass++;
      chk++; if ({alu_aluop, alu_funct, alu_a, alu_b} !== {3'b111, 6'b000001, 32'd5, 32'd7})
         $display("FAIL single_alu_in got=%b/%b/%0d/%0d exp=111/000001/5/7", alu_aluop, alu_funct, alu_a, alu_b); else pass++;
      chk++; if (rsp_valid !== 2'b00) $display("FAIL single_rsp_early got=%b exp=00", rsp_valid); else pass++;
      @(negedge clk);
      chk++; if (rsp_valid !== 2'b01) $display("FAIL single_rsp_valid got=%b exp=01", rsp_valid); else pass++;
      chk++; if (rsp_data !== 32'd12) $display("FAIL single_rsp_data got=%0d exp=12", rsp_data); else pass++;
      @(negedge clk);
      chk++; if (rsp_valid !== 2'b00) $display("FAIL single_rsp_done got=%b exp=00", rsp_valid); else pass++;
      chk++; if ({alu_a, alu_b} !== {32'd5, 32'd7}) $display("FAIL single_alu_hold got=%0d/%0d exp=5/7", alu_a, alu_b); else pass++;
   endtask

   task automatic test_contention();
      logic [1:0]    exp;
      logic [DW-1:0] expd;
      do_reset();
      rsp_ready = 2'b11;
      set_op(0, 3'b111, 6'b000001, 32'd100, 32'd1);
      set_op(1, 3'b101, 6'b000000, 32'd50, 32'd8);
      req_valid = 2'b11; #1;
      for (int k = 0; k < 4; k++) begin
         exp  = (k % 2 == 1) ? 2'b10 : 2'b01;
         expd = (k % 2 == 1) ? 32'd42 : 32'd101;
         for (int c = 0; c < 10 && req_ready == 2'b00; c++) @(negedge clk);
         chk++; if (req_ready !== exp) $display("FAIL cont_grant%0d got=%b exp=%b", k, req_ready, exp); else pass++;
         @(negedge clk);
         for (int c = 0; c < 10 && rsp_valid == 2'b00; c++) @(negedge clk);
         chk++; if (rsp_valid !== exp) $display("FAIL cont_rsp%0d got=%b exp=%b", k, rsp_valid, exp); else pass++;
         chk++; if (rsp_data !== expd) $display("FAIL cont_data%0d got=%0d exp=%0d", k, rsp_data, expd); else pass++;
         @(negedge clk);
      end
      req_valid = '0;
      repeat (2) @(negedge clk);
   endtask

   task automatic test_back_pressure();
      rsp_ready = 2'b01;
      set_op(1, 3'b111, 6'b000001, 32'd20, 32'd22);
      req_valid = 2'b10; #1;
      chk++; if (req_ready !== 2'b10) $display("FAIL bp_grant got=%b exp=10", req_ready); else pass++;
      @(posedge clk); #1;
      req_valid = 2'b01;
      repeat (2) @(negedge clk);
      for (int k = 0; k < 5; k++) begin
         chk++; if (rsp_valid !== 2'b10 || rsp_data !== 32'd42)
            $display("FAIL bp_hold%0d got=%b/%0d exp=10/42", k, rsp_valid, rsp_data); else pass++;
         chk++; if (req_ready !== 2'b00) $display("FAIL bp_no_grant%0d got=%b exp=00", k, req_ready); else pass++;
         @(negedge clk);
      end
      rsp_ready = 2'b10;
      @(negedge clk);
      chk++; if (rsp_valid !== 2'b00) $display("FAIL bp_release got=%b exp=00", rsp_valid); else pass++;
      chk++; if (req_ready !== 2'b01) $display("FAIL bp_next_grant got=%b exp=01", req_ready); else pass++;
      @(posedge clk); #1;
      req_valid = '0;
      rsp_ready = 2'b11;
      repeat (4) @(negedge clk);
   endtask

   task automatic test_zero_flag();
      rsp_ready = 2'b11;
      issue_wait(1, 3'b101, 6'b000000, 32'h1234, 32'h1234);
      chk++; if (rsp_valid !== 2'b10) $display("FAIL zero_rsp_valid got=%b exp=10", rsp_valid); else pass++;
      chk++; if (rsp_zero !== 1'b1 || rsp_data !== 32'd0)
         $display("FAIL zero_set got=%b/%h exp=1/0", rsp_zero, rsp_data); else pass++;
      @(negedge clk);
      issue_wait(1, 3'b101, 6'b000000, 32'd1, 32'd2);
      chk++; if (rsp_zero !== 1'b0 || rsp_data !== 32'hFFFF_FFFF)
         $display("FAIL zero_clr got=%b/%h exp=0/ffffffff", rsp_zero, rsp_data); else pass++;
      repeat (2) @(negedge clk);
   endtask

   task automatic test_lat3();
      l3_rsp_ready    = 2'b01;
      l3_req_aluop[0] = 3'b111;
      l3_req_funct[0] = 6'b000001;
      l3_req_a[0]     = 32'd5;
      l3_req_b[0]     = 32'd7;
      l3_req_valid    = 2'b01; #1;
      chk++; if (l3_req_ready !== 2'b01) $display("FAIL lat3_grant got=%b exp=01", l3_req_ready); else pass++;
      @(posedge clk); #1;
      l3_req_valid = '0;
      for (int k = 1; k <= 3; k++) begin
         @(negedge clk);
         chk++; if (l3_rsp_valid !== 2'b00) $display("FAIL lat3_exec%0d_rsp got=%b exp=00", k, l3_rsp_valid); else pass++;
         chk++; if ({l3_alu_a, l3_alu_b} !== {32'd5, 32'd7})
            $display("FAIL lat3_exec%0d_alu got=%0d/%0d exp=5/7", k, l3_alu_a, l3_alu_b); else pass++;
      end
      @(negedge clk);
      chk++; if (l3_rsp_valid !== 2'b01) $display("FAIL lat3_rsp_valid got=%b exp=01", l3_rsp_valid); else pass++;
      chk++; if (l3_rsp_data !== 32'd12) $display("FAIL lat3_rsp_data got=%0d exp=12", l3_rsp_data); else pass++;
      @(negedge clk);
      chk++; if (l3_rsp_valid !== 2'b00) $display("FAIL lat3_done got=%b exp=00", l3_rsp_valid); else pass++;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1);
   end

   initial begin
      test_reset();
      test_single();
      test_contention();
      test_back_pressure();
      test_zero_flag();
      test_lat3();
      $display("%0d/%0d checks passed", pass, chk);
      $finish;
   end
endmodule
